// File: rtl/gb_pkg.sv
// Shared types and elaboration helpers for ghostbus branch bridges.
package gb_pkg;

    // Struct fields are sized for the widest supported child address and data.
    localparam int GB_MAX_AW = 32;
    localparam int GB_MAX_DW = 64;

    typedef struct packed {
        logic                 hit;
        logic                 wstb;
        logic [GB_MAX_AW-1:0] addr;
        logic [GB_MAX_DW-1:0] wdata;
    } gb_req_t;

    function automatic bit gb_window_aligned(input logic [63:0] base, input int child_aw);
        return (base & ((64'd1 << child_aw) - 64'd1)) == 64'd0;
    endfunction

    function automatic int gb_rd_latency(input int pipe, input int child_rl);
        return pipe + child_rl + 1;
    endfunction

endpackage

// File: rtl/gb_delay_line.sv
// Fixed-depth shift register with synchronous reset of every stage.
module gb_delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage_q [DEPTH];
    logic [W-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/gb_branch_bridge.sv
// Hangs a child ghostbus branch off a parent bus at an aligned window,
// returning child read data at the fixed latency RD_LATENCY.
module gb_branch_bridge
    import gb_pkg::*;
#(
    parameter int            AW       = 24,
    parameter int            DW       = 32,
    parameter int            CHILD_AW = 8,
    parameter logic [AW-1:0] BASE     = '0,
    parameter int            PIPE     = 1,
    parameter int            CHILD_RL = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AW-1:0]       p_addr,
    input  logic [DW-1:0]       p_wdata,
    input  logic                p_wstb,
    output logic [DW-1:0]       p_rdata,
    output logic [CHILD_AW-1:0] c_addr,
    output logic [DW-1:0]       c_wdata,
    output logic                c_wstb,
    input  logic [DW-1:0]       c_rdata,
    output logic                hit
);

    localparam int RD_LATENCY = gb_rd_latency(PIPE, CHILD_RL);
    localparam int TAG_DEPTH  = RD_LATENCY - PIPE - 1;
    localparam int REQ_W      = $bits(gb_req_t);

    if (CHILD_AW < 1 || CHILD_AW >= AW || CHILD_AW > GB_MAX_AW) begin : g_bad_child_aw
        $error("gb_branch_bridge: CHILD_AW out of range");
    end
    if (DW < 1 || DW > GB_MAX_DW) begin : g_bad_dw
        $error("gb_branch_bridge: DW out of range");
    end
    if (PIPE < 1 || PIPE > 4 || CHILD_RL < 1 || CHILD_RL > 4) begin : g_bad_latency
        $error("gb_branch_bridge: PIPE and CHILD_RL must be 1..4");
    end
    if (!gb_window_aligned(64'(BASE), CHILD_AW)) begin : g_bad_base
        $error("gb_branch_bridge: BASE is not aligned to the child window");
    end

    logic                hit_p0;
    logic [CHILD_AW-1:0] hold_addr_q, hold_addr_d;
    logic [DW-1:0]       hold_wdata_q, hold_wdata_d;
    logic [DW-1:0]       p_rdata_q, p_rdata_d;
    gb_req_t             req_p0;
    gb_req_t             req_out;
    logic                tag_in;
    logic                tag_out;

    // Stage 0: decode; misses carry the last hit's addr/wdata so c_* never toggle on them.
    always_comb begin
        hit_p0       = (p_addr[AW-1:CHILD_AW] == BASE[AW-1:CHILD_AW]);
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        if (hit_p0) begin
            hold_addr_d  = p_addr[CHILD_AW-1:0];
            hold_wdata_d = p_wdata;
        end
        req_p0       = '0;
        req_p0.hit   = hit_p0;
        req_p0.wstb  = p_wstb & hit_p0;
        req_p0.addr  = GB_MAX_AW'(hold_addr_d);
        req_p0.wdata = GB_MAX_DW'(hold_wdata_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
        end else begin
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
        end
    end

    gb_delay_line #(
        .W     (REQ_W),
        .DEPTH (PIPE)
    ) u_req_pipe (
        .clk (clk),
        .rst (rst),
        .d   (req_p0),
        .q   (req_out)
    );

    // Last request stage: drive the child and launch the read tag.
    assign c_addr  = req_out.addr[CHILD_AW-1:0];
    assign c_wdata = req_out.wdata[DW-1:0];
    assign c_wstb  = req_out.wstb & req_out.hit;
    assign hit     = req_out.hit;
    assign tag_in  = req_out.hit & ~req_out.wstb;

    gb_delay_line #(
        .W     (1),
        .DEPTH (TAG_DEPTH)
    ) u_tag_chain (
        .clk (clk),
        .rst (rst),
        .d   (tag_in),
        .q   (tag_out)
    );

    // Return stage: zero the parent data unless this slot is a hit read.
    always_comb begin
        p_rdata_d = '0;
        if (tag_out) begin
            p_rdata_d = c_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_rdata_q <= '0;
        end else begin
            p_rdata_q <= p_rdata_d;
        end
    end

    assign p_rdata = p_rdata_q;

endmodule

// File: tb/tb_gb_branch_bridge.sv
// Three bridge configurations driven by shared directed and random parent traffic,
// checked each cycle against a window/latency reference model.
module tb_gb_branch_bridge;

    localparam int ND   = 3;
    localparam int NCYC = 640;

    logic        clk = 1'b0;
    logic [2:0]  rst_v;
    logic [23:0] p_addr;
    logic [31:0] p_wdata;
    logic        p_wstb;

    logic [31:0] p_rdata_o [ND];
    logic [7:0]  c_addr_o  [ND];
    logic [31:0] c_wdata_o [ND];
    logic        c_wstb_o  [ND];
    logic        hit_o     [ND];
    logic [31:0] c_rdata_i [ND];

    logic [31:0] mem  [256];
    logic [31:0] ch_q [ND][4];

    logic        exp_hit  [ND][NCYC];
    logic        exp_wstb [ND][NCYC];
    logic [7:0]  exp_addr [ND][NCYC];
    logic [31:0] exp_wd   [ND][NCYC];
    logic [31:0] exp_rd   [ND][NCYC];
    int          last_off [ND];
    logic [31:0] last_wd  [ND];

    int cyc;
    int n_checks;
    int n_errors;

    always #5 clk = ~clk;

    // Child model: read-only memory answering CHILD_RL cycles after c_addr.
    always @(posedge clk) begin
        for (int d = 0; d < ND; d++) begin
            ch_q[d][0] <= mem[c_addr_o[d]];
            for (int i = 1; i < 4; i++) begin
                ch_q[d][i] <= ch_q[d][i-1];
            end
        end
    end
    assign c_rdata_i[0] = ch_q[0][0];
    assign c_rdata_i[1] = ch_q[1][0];
    assign c_rdata_i[2] = ch_q[2][2];

    gb_branch_bridge #(.AW(24), .DW(32), .CHILD_AW(8), .BASE(24'h000100), .PIPE(1), .CHILD_RL(1)) dut0 (
        .clk(clk), .rst(rst_v[0]), .p_addr(p_addr), .p_wdata(p_wdata), .p_wstb(p_wstb),
        .p_rdata(p_rdata_o[0]), .c_addr(c_addr_o[0]), .c_wdata(c_wdata_o[0]), .c_wstb(c_wstb_o[0]),
        .c_rdata(c_rdata_i[0]), .hit(hit_o[0]));

    gb_branch_bridge #(.AW(24), .DW(32), .CHILD_AW(8), .BASE(24'h000100), .PIPE(3), .CHILD_RL(1)) dut1 (
        .clk(clk), .rst(rst_v[1]), .p_addr(p_addr), .p_wdata(p_wdata), .p_wstb(p_wstb),
        .p_rdata(p_rdata_o[1]), .c_addr(c_addr_o[1]), .c_wdata(c_wdata_o[1]), .c_wstb(c_wstb_o[1]),
        .c_rdata(c_rdata_i[1]), .hit(hit_o[1]));

    gb_branch_bridge #(.AW(24), .DW(32), .CHILD_AW(8), .BASE(24'h000400), .PIPE(2), .CHILD_RL(3)) dut2 (
        .clk(clk), .rst(rst_v[2]), .p_addr(p_addr), .p_wdata(p_wdata), .p_wstb(p_wstb),
        .p_rdata(p_rdata_o[2]), .c_addr(c_addr_o[2]), .c_wdata(c_wdata_o[2]), .c_wstb(c_wstb_o[2]),
        .c_rdata(c_rdata_i[2]), .hit(hit_o[2]));

    function automatic int pipe_of(input int d);
        case (d)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int crl_of(input int d);
        return (d == 2) ? 3 : 1;
    endfunction

    function automatic int base_of(input int d);
        return (d == 2) ? 'h400 : 'h100;
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s dut%0d cycle %0d: got %h expected %h", tag, d, cyc, obs, expv);
        end
    endtask

    task automatic clear_slot(input int d, input int m);
        exp_hit[d][m]  = 1'b0;
        exp_wstb[d][m] = 1'b0;
        exp_addr[d][m] = 8'h00;
        exp_wd[d][m]   = 32'h0;
        exp_rd[d][m]   = 32'h0;
    endtask

    // One parent cycle: update the model, clock the DUTs, compare every output.
    task automatic step(input logic [23:0] a, input logic [31:0] wd, input logic ws, input logic [2:0] r);
        p_addr  = a;
        p_wdata = wd;
        p_wstb  = ws;
        rst_v   = r;
        for (int d = 0; d < ND; d++) begin
            int off;
            int rl;
            bit inw;
            off = int'(a) - base_of(d);
            inw = (off >= 0) && (off < 256);
            rl  = pipe_of(d) + crl_of(d) + 1;
            if (r[d]) begin
                for (int m = cyc + 1; m <= cyc + rl; m++) clear_slot(d, m);
                last_off[d] = 0;
                last_wd[d]  = 32'h0;
            end else begin
                if (inw) begin
                    last_off[d] = off;
                    last_wd[d]  = wd;
                end
                exp_hit[d][cyc + pipe_of(d)]  = inw;
                exp_wstb[d][cyc + pipe_of(d)] = inw && ws;
                exp_addr[d][cyc + pipe_of(d)] = 8'(last_off[d]);
                exp_wd[d][cyc + pipe_of(d)]   = last_wd[d];
                exp_rd[d][cyc + rl]           = (inw && !ws) ? mem[8'(off)] : 32'h0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < ND; d++) begin
            chk("c_wstb",  d, 32'(c_wstb_o[d]),  32'(exp_wstb[d][cyc]));
            chk("hit",     d, 32'(hit_o[d]),     32'(exp_hit[d][cyc]));
            chk("c_addr",  d, 32'(c_addr_o[d]),  32'(exp_addr[d][cyc]));
            chk("c_wdata", d, c_wdata_o[d],      exp_wd[d][cyc]);
            chk("p_rdata", d, p_rdata_o[d],      exp_rd[d][cyc]);
        end
    endtask

    initial begin
        logic [23:0] ra;
        logic [2:0]  rr;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[8'hff] = 32'hcafef00d;
        for (int d = 0; d < ND; d++) begin
            last_off[d] = 0;
            last_wd[d]  = 32'h0;
            for (int m = 0; m < NCYC; m++) clear_slot(d, m);
        end

        // Reset state
        for (int i = 0; i < 3; i++) step(24'h000105, 32'h11111111, 1'b1, 3'b111);

        // Hit write, miss write (c_addr holds), hit read, miss read
        step(24'h000105, 32'hdeadbeef, 1'b1, 3'b000);
        step(24'h000205, 32'h12345678, 1'b1, 3'b000);
        step(24'h0001ff, 32'h0,        1'b0, 3'b000);
        step(24'h0000ff, 32'h0,        1'b0, 3'b000);

        // Back-to-back hit/miss/hit reads
        step(24'h000100, 32'h0, 1'b0, 3'b000);
        step(24'h000300, 32'h0, 1'b0, 3'b000);
        step(24'h000101, 32'h0, 1'b0, 3'b000);

        // Window edges of both bases
        step(24'h000200, 32'h0, 1'b0, 3'b000);
        step(24'h0003ff, 32'h0, 1'b0, 3'b000);
        step(24'h000400, 32'h0, 1'b0, 3'b000);
        step(24'h0004ff, 32'h0, 1'b0, 3'b000);
        step(24'h000500, 32'h0, 1'b0, 3'b000);
        step(24'h0001ff, 32'h0, 1'b0, 3'b000);

        // Hit reads returning while miss writes are issued
        step(24'h000110, 32'h0,        1'b0, 3'b000);
        step(24'h000120, 32'h0,        1'b0, 3'b000);
        step(24'h000205, 32'h0badf00d, 1'b1, 3'b000);
        step(24'h000305, 32'h0badcafe, 1'b1, 3'b000);
        for (int i = 0; i < 6; i++) step(24'h000000, 32'h0, 1'b0, 3'b000);

        // Reset one cycle after a hit write on the PIPE=3 bridge, then a fresh read
        step(24'h000105, 32'ha5a5a5a5, 1'b1, 3'b000);
        step(24'h000000, 32'h0,        1'b0, 3'b010);
        step(24'h0001ff, 32'h0,        1'b0, 3'b000);
        for (int i = 0; i < 6; i++) step(24'h000000, 32'h0, 1'b0, 3'b000);

        // Reset with reads in flight on the other two bridges
        step(24'h000142, 32'h0, 1'b0, 3'b000);
        step(24'h000442, 32'h0, 1'b0, 3'b000);
        step(24'h000143, 32'h0, 1'b0, 3'b101);
        step(24'h000444, 32'h0, 1'b0, 3'b000);
        for (int i = 0; i < 6; i++) step(24'h000000, 32'h0, 1'b0, 3'b000);

        // Random traffic around both windows with sparse resets
        for (int i = 0; i < 380; i++) begin
            case ($urandom_range(0, 3))
                0:       ra = 24'($urandom_range('h0f0, 'h210));
                1:       ra = 24'($urandom_range('h3f0, 'h510));
                2:       ra = 24'($urandom);
                default: ra = 24'h000100 + 24'($urandom_range(0, 255));
            endcase
            for (int d = 0; d < ND; d++) rr[d] = ($urandom_range(0, 39) == 0);
            step(ra, $urandom, 1'($urandom_range(0, 1)), rr);
        end
        for (int i = 0; i < 8; i++) step(24'h000000, 32'h0, 1'b0, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
